// File: rtl/memory_stage.sv
// SEQ Y86-64 memory stage: handshaked IDLE -> ACCESS -> RESP access to an
// internal byte-addressable little-endian data memory, producing valM and stat.
// Optional build macro: DMEM_ALIGN_CHECK_EN (unaligned 8-byte accesses flagged as address errors).
module memory_stage #(
   parameter int unsigned DEPTH = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [3:0]  icode,
   input  logic [63:0] valE,
   input  logic [63:0] valA,
   input  logic [63:0] valP,
   input  logic        imem_error,
   input  logic        instr_valid,
   output logic        busy,
   output logic        out_valid,
   output logic [63:0] valM,
   output logic        dmem_error,
   output logic [2:0]  stat
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam logic [63:0] LAST_ADDR = 64'(DEPTH - 8);

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t state, next_state;

   logic [3:0]  icode_q;
   logic [63:0] valE_q, valA_q, valP_q;
   logic        imem_error_q, instr_valid_q;

   logic [7:0]  mem [DEPTH];

   logic          is_wr, is_rd, addr_err, commit;
   logic [63:0]   addr, wdata, rdata;
   logic [AW-1:0] base;
   logic [2:0]    new_stat;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state and handshake outputs
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      out_valid  = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid) next_state = ACCESS;
         end
         ACCESS: begin
            busy       = 1'b1;
            next_state = RESP;
         end
         RESP: begin
            busy       = 1'b1;
            out_valid  = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Capture the request while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         icode_q       <= '0;
         valE_q        <= '0;
         valA_q        <= '0;
         valP_q        <= '0;
         imem_error_q  <= 1'b0;
         instr_valid_q <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         icode_q       <= icode;
         valE_q        <= valE;
         valA_q        <= valA;
         valP_q        <= valP;
         imem_error_q  <= imem_error;
         instr_valid_q <= instr_valid;
      end
   end

   // Decode operation, address check, read data assembly and status priority
   always_comb begin
      is_wr = (icode_q == 4'h4) || (icode_q == 4'hA) || (icode_q == 4'h8);
      is_rd = (icode_q == 4'h5) || (icode_q == 4'hB) || (icode_q == 4'h9);
      addr  = ((icode_q == 4'hB) || (icode_q == 4'h9)) ? valA_q : valE_q;
      wdata = (icode_q == 4'h8) ? valP_q : valA_q;
      base  = addr[AW-1:0];
`ifdef DMEM_ALIGN_CHECK_EN
      addr_err = (is_wr || is_rd) && ((addr > LAST_ADDR) || (addr[2:0] != 3'b000));
`else
      addr_err = (is_wr || is_rd) && (addr > LAST_ADDR);
`endif
      rdata = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         rdata[i*8 +: 8] = mem[base + AW'(i)];
      end
      if (imem_error_q || addr_err) new_stat = STAT_ADR;
      else if (!instr_valid_q)      new_stat = STAT_INS;
      else if (icode_q == 4'h0)     new_stat = STAT_HLT;
      else                          new_stat = STAT_AOK;
      // Nothing commits once the machine has stopped or this access faults.
      commit = (state == ACCESS) && (stat == STAT_AOK) && (new_stat == STAT_AOK);
   end

   // Data memory write; gated by rst_n so a reset during ACCESS drops the write
   always_ff @(posedge clk) begin
      if (rst_n && commit && is_wr) begin
         for (int unsigned i = 0; i < 8; i++) begin
            mem[base + AW'(i)] <= wdata[i*8 +: 8];
         end
      end
   end

   // Result registers; status is sticky until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valM       <= '0;
         dmem_error <= 1'b0;
         stat       <= STAT_AOK;
      end else if (state == ACCESS && stat == STAT_AOK) begin
         dmem_error <= addr_err;
         stat       <= new_stat;
         if (commit && is_rd) valM <= rdata;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: scoreboard queue filled by the
// stimulus thread, drained by a monitor on every out_valid pulse.
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [3:0]  icode = '0;
   logic [63:0] valE = '0, valA = '0, valP = '0;
   logic        imem_error = 1'b0;
   logic        instr_valid = 1'b1;
   logic        busy, out_valid, dmem_error;
   logic [63:0] valM;
   logic [2:0]  stat;

   typedef struct {
      logic [63:0] valM;
      logic        dmem;
      logic [2:0]  stat;
      int          id;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   pulses = 0;
   int   issued = 0;

   memory_stage #(.DEPTH(1024)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .icode(icode),
      .valE(valE), .valA(valA), .valP(valP), .imem_error(imem_error),
      .instr_valid(instr_valid), .busy(busy), .out_valid(out_valid),
      .valM(valM), .dmem_error(dmem_error), .stat(stat)
   );

   always #5 clk = ~clk;

   // Monitor: compare every response against the oldest expectation
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         exp_t e;
         pulses++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid: got valM=%h stat=%0d, required no response", valM, stat);
         end else begin
            e = sb.pop_front();
            if (valM !== e.valM || dmem_error !== e.dmem || stat !== e.stat) begin
               errors++;
               $display("FAIL resp_%0d: got valM=%h dmem_error=%b stat=%0d, required valM=%h dmem_error=%b stat=%0d",
                        e.id, valM, dmem_error, stat, e.valM, e.dmem, e.stat);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      imem_error = 1'b0;
      instr_valid = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One transaction with timing checks: accept, response 2 edges after sampling, release
   task automatic issue(input int id, input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                        input logic [63:0] p, input logic ie, input logic iv,
                        input logic [63:0] x_valM, input logic x_dmem, input logic [2:0] x_stat);
      exp_t x;
      x.valM = x_valM; x.dmem = x_dmem; x.stat = x_stat; x.id = id;
      sb.push_back(x);
      issued++;
      icode = ic; valE = e; valA = a; valP = p; imem_error = ie; instr_valid = iv;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("accept_%0d", id), {62'd0, busy, out_valid}, 64'd2);
      @(negedge clk);
      check($sformatf("latency_%0d", id), {63'd0, out_valid}, 64'd1);
      @(negedge clk);
      check($sformatf("release_%0d", id), {62'd0, busy, out_valid}, 64'd0);
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("reset_valM", valM, 64'd0);
      check("reset_stat", {61'd0, stat}, 64'd1);
      check("reset_dmem_error", {63'd0, dmem_error}, 64'd0);
      do_reset();

      // Basic reads/writes
      issue(1, 4'h4, 64'h10, 64'h1122334455667788, 64'h0, 1'b0, 1'b1, 64'h0, 1'b0, 3'd1);
      issue(2, 4'h5, 64'h10, 64'h0, 64'h0, 1'b0, 1'b1, 64'h1122334455667788, 1'b0, 3'd1);
      issue(3, 4'hA, 64'h3F8, 64'hDEAD, 64'h0, 1'b0, 1'b1, 64'h1122334455667788, 1'b0, 3'd1);
      issue(4, 4'hB, 64'h400, 64'h3F8, 64'h0, 1'b0, 1'b1, 64'hDEAD, 1'b0, 3'd1);
      issue(5, 4'h8, 64'h3F0, 64'h1234, 64'h40, 1'b0, 1'b1, 64'hDEAD, 1'b0, 3'd1);
      issue(6, 4'h9, 64'h400, 64'h3F0, 64'h0, 1'b0, 1'b1, 64'h40, 1'b0, 3'd1);
      issue(7, 4'h4, 64'h0, 64'hA5A5, 64'h0, 1'b0, 1'b1, 64'h40, 1'b0, 3'd1);
      issue(8, 4'h4, 64'h20, 64'h7777, 64'h0, 1'b0, 1'b1, 64'h40, 1'b0, 3'd1);
      issue(9, 4'h4, 64'h18, 64'h0123456789ABCDEF, 64'h0, 1'b0, 1'b1, 64'h40, 1'b0, 3'd1);
`ifdef DMEM_ALIGN_CHECK_EN
      issue(10, 4'h5, 64'h13, 64'h0, 64'h0, 1'b0, 1'b1, 64'h40, 1'b1, 3'd3);
`else
      issue(10, 4'h5, 64'h13, 64'h0, 64'h0, 1'b0, 1'b1, 64'hABCDEF1122334455, 1'b0, 3'd1);
`endif

      // Out-of-range write, then sticky ADR blocks a legal write
      do_reset();
      issue(11, 4'h4, 64'h3F9, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 3'd3);
      issue(12, 4'h4, 64'h0, 64'h55, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 3'd3);
      do_reset();
      issue(13, 4'h5, 64'h3F8, 64'h0, 64'h0, 1'b0, 1'b1, 64'hDEAD, 1'b0, 3'd1);
      issue(14, 4'h5, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 64'hA5A5, 1'b0, 3'd1);
      do_reset();
      issue(15, 4'h5, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 3'd3);

      // Status priority
      do_reset();
      issue(16, 4'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b0, 3'd2);
      do_reset();
      issue(17, 4'h1, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 3'd4);
      do_reset();
      issue(18, 4'h1, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 3'd3);

      // in_valid held high while busy must be ignored
      do_reset();
      begin
         exp_t x;
         x.valM = 64'h1122334455667788; x.dmem = 1'b0; x.stat = 3'd1; x.id = 19;
         sb.push_back(x);
         issued++;
         icode = 4'h5; valE = 64'h10; valA = '0; in_valid = 1'b1;
         @(negedge clk);
         icode = 4'h4; valE = 64'h10; valA = 64'h0;
         @(negedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         repeat (3) @(negedge clk);
         check("busy_ignore_pulses", 64'(pulses), 64'(issued));
      end
      issue(20, 4'h5, 64'h10, 64'h0, 64'h0, 1'b0, 1'b1, 64'h1122334455667788, 1'b0, 3'd1);

      // Reset during ACCESS drops the write
      do_reset();
      icode = 4'h4; valE = 64'h20; valA = 64'hBBBB; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("midop_busy_before", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("midop_busy", {63'd0, busy}, 64'd0);
      check("midop_out_valid", {63'd0, out_valid}, 64'd0);
      check("midop_stat", {61'd0, stat}, 64'd1);
      check("midop_valM", valM, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(21, 4'h5, 64'h20, 64'h0, 64'h0, 1'b0, 1'b1, 64'h7777, 1'b0, 3'd1);

      repeat (3) @(negedge clk);
      check("pending_expectations", 64'(sb.size()), 64'd0);
      check("total_pulses", 64'(pulses), 64'(issued));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
